reg_writeback_queue: RTL and testbench

Writer-side front end for the 32x32 register file write port (RegWrite/WriteReg/WriteData). After reset it zeroes every register with an INIT sweep. It then accepts write-back requests from the datapath over a valid/ready handshake, buffers them in a small FIFO and drains them one per cycle onto the register-file write port. A combinational lookup port exposes pending (not yet committed) writes so read-side logic can bypass stale register-file data.

---
 rtl/reg_writeback_queue_if.sv | 32 +++
 rtl/reg_writeback_queue.sv | 138 +++++++++++++
 tb/tb_reg_writeback_queue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Write-back request, register-file write port and pending-write lookup bundle
// for reg_writeback_queue. The queue uses the slave view; the datapath uses master.
interface reg_writeback_queue_if #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 5,
  parameter int DEPTH        = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                    WbValid;
  logic                    WbReady;
  logic [ADDRESS_SIZE-1:0] WbReg;
  logic [WORD_SIZE-1:0]    WbData;
  logic                    RegWrite;
  logic [ADDRESS_SIZE-1:0] WriteReg;
  logic [WORD_SIZE-1:0]    WriteData;
  logic                    InitDone;
  logic [ADDRESS_SIZE-1:0] LookupReg;
  logic                    LookupHit;
  logic [WORD_SIZE-1:0]    LookupData;
  logic [CNT_W-1:0]        Pending;

  modport master (
    output WbValid, WbReg, WbData, LookupReg,
    input  WbReady, RegWrite, WriteReg, WriteData, InitDone, LookupHit, LookupData, Pending
  );

  modport slave (
    input  WbValid, WbReg, WbData, LookupReg,
    output WbReady, RegWrite, WriteReg, WriteData, InitDone, LookupHit, LookupData, Pending
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register-file writer front end: zeroing sweep after reset, then a small FIFO
// of write-backs drained one per cycle, with a youngest-first pending lookup.
module rwq_slot_match #(
  parameter int ADDRESS_SIZE = 5
) (
  input  logic                    i_vld,
  input  logic [ADDRESS_SIZE-1:0] i_rd,
  input  logic [ADDRESS_SIZE-1:0] i_key,
  output logic                    o_hit
);
  assign o_hit = i_vld && (i_rd == i_key);
endmodule

module reg_writeback_queue #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 5,
  parameter int DEPTH        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_writeback_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] rd;
    logic [WORD_SIZE-1:0]    data;
  } wb_ent_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDRESS_SIZE-1:0] r_sweep;
  wb_ent_t                 r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wptr, r_rptr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_wr_en;
  logic [ADDRESS_SIZE-1:0] r_wr_reg;
  logic [WORD_SIZE-1:0]    r_wr_data;
  logic                    r_init_done;

  logic                    w_ready, w_push, w_pop;
  logic [DEPTH-1:0]        w_slot_hit;
  logic                    w_lk_hit;
  logic [WORD_SIZE-1:0]    w_lk_data;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      ST_INIT: if (r_sweep == '1) w_state_nxt = ST_RUN;
      ST_RUN:  w_ready = (r_cnt != CNT_W'(DEPTH));
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Index-0 requests complete the handshake but never occupy a slot.
  assign w_push = w_ready && bus.WbValid && (bus.WbReg != '0);
  assign w_pop  = (r_state == ST_RUN) && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= r_sweep;
        r_wr_data <= '0;
        r_sweep   <= r_sweep + ADDRESS_SIZE'(1);
        if (r_sweep == '1) r_init_done <= 1'b1;
      end else begin
        if (w_pop) begin
          r_wr_en   <= 1'b1;
          r_wr_reg  <= r_mem[r_rptr].rd;
          r_wr_data <= r_mem[r_rptr].data;
          r_rptr    <= r_rptr + PTR_W'(1);
        end else begin
          r_wr_en   <= 1'b0;
        end
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Payload storage needs no reset: validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{rd: bus.WbReg, data: bus.WbData};
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    logic [PTR_W-1:0] w_age;
    assign w_age = PTR_W'(j) - r_rptr;
    rwq_slot_match #(.ADDRESS_SIZE(ADDRESS_SIZE)) u_match (
      .i_vld ({1'b0, w_age} < r_cnt),
      .i_rd  (r_mem[j].rd),
      .i_key (bus.LookupReg),
      .o_hit (w_slot_hit[j])
    );
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_data = '0;
    if (r_state == ST_RUN && bus.LookupReg != '0) begin
      if (r_wr_en && r_wr_reg == bus.LookupReg) begin
        w_lk_hit  = 1'b1;
        w_lk_data = r_wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_slot_hit[r_rptr + PTR_W'(i)]) begin
          w_lk_hit  = 1'b1;
          w_lk_data = r_mem[r_rptr + PTR_W'(i)].data;
        end
      end
    end
  end

  assign bus.WbReady    = w_ready;
  assign bus.RegWrite   = r_wr_en;
  assign bus.WriteReg   = r_wr_reg;
  assign bus.WriteData  = r_wr_data;
  assign bus.InitDone   = r_init_done;
  assign bus.LookupHit  = w_lk_hit;
  assign bus.LookupData = w_lk_data;
  assign bus.Pending    = r_cnt;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the pending writes.
module tb_reg_writeback_queue;
  localparam int WS = 32;
  localparam int AS = 5;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_queue_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .DEPTH(DP)) bus ();

  reg_writeback_queue #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [AS-1:0] rd;
    logic [WS-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic          m_en;
  logic [AS-1:0] m_reg;
  logic [WS-1:0] m_data;
  bit            m_run, m_done;
  int            m_sweep;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_en = 1'b0; m_reg = '0; m_data = '0;
    m_run = 1'b0; m_done = 1'b0; m_sweep = 0;
  endfunction

  function automatic void m_lookup(input logic [AS-1:0] k, output logic hit, output logic [WS-1:0] d);
    hit = 1'b0; d = '0;
    if (!m_run || k == '0) return;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == k) begin hit = 1'b1; d = q[i].data; return; end
    if (m_en && m_reg == k) begin hit = 1'b1; d = m_data; end
  endfunction

  // One clock: drive at negedge, check every output, then advance the model past the posedge.
  task automatic cycle(input logic v, input logic [AS-1:0] r, input logic [WS-1:0] d,
                       input logic [AS-1:0] lk, output bit acc);
    logic          hit;
    logic [WS-1:0] ld;
    bit            rdy;
    @(negedge clk);
    bus.WbValid = v; bus.WbReg = r; bus.WbData = d; bus.LookupReg = lk;
    #1;
    rdy = m_run && (q.size() < DP);
    m_lookup(lk, hit, ld);
    chk("RegWrite",   bus.RegWrite,   m_en);
    chk("WriteReg",   bus.WriteReg,   m_reg);
    chk("WriteData",  bus.WriteData,  m_data);
    chk("InitDone",   bus.InitDone,   m_done);
    chk("Pending",    bus.Pending,    q.size());
    chk("WbReady",    bus.WbReady,    rdy);
    chk("LookupHit",  bus.LookupHit,  hit);
    chk("LookupData", bus.LookupData, ld);
    acc = v && rdy;
    @(posedge clk);
    if (!m_run) begin
      m_en = 1'b1; m_reg = AS'(m_sweep); m_data = '0;
      if (m_sweep == (1 << AS) - 1) begin m_run = 1'b1; m_done = 1'b1; end
      m_sweep++;
    end else begin
      if (q.size() != 0) begin
        ent_t e;
        e = q.pop_front();
        m_en = 1'b1; m_reg = e.rd; m_data = e.data;
      end else begin
        m_en = 1'b0;
      end
      if (acc && r != '0) q.push_back('{rd: r, data: d});
    end
  endtask

  task automatic idle(input int n, input logic [AS-1:0] lk);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, lk, acc);
  endtask

  task automatic push(input logic [AS-1:0] r, input logic [WS-1:0] d, input logic [AS-1:0] lk);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 16 && !acc; n++) cycle(1'b1, r, d, lk, acc);
    chk("push_accept", {31'd0, acc}, 32'd1);
  endtask

  // Assert reset between edges, check asynchronous clear, release clear of an edge.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_RegWrite", bus.RegWrite, 1'b0);
    chk("rst_Pending",  bus.Pending,  '0);
    chk("rst_WbReady",  bus.WbReady,  1'b0);
    chk("rst_InitDone", bus.InitDone, 1'b0);
    m_reset();
    bus.WbValid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    bus.WbValid = 1'b0; bus.WbReg = '0; bus.WbData = '0; bus.LookupReg = '0;
    m_reset();
    #1;
    chk("reset_RegWrite",  bus.RegWrite,  1'b0);
    chk("reset_WriteReg",  bus.WriteReg,  '0);
    chk("reset_WriteData", bus.WriteData, '0);
    chk("reset_InitDone",  bus.InitDone,  1'b0);
    chk("reset_Pending",   bus.Pending,   '0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // INIT sweep, with a request offered that must be refused.
    for (int i = 0; i < 34; i++) cycle(1'b1, 5'd9, 32'h1234, AS'(i), acc);
    idle(2, 5'd9);

    push(5'd5, 32'hDEADBEEF, 5'd5);
    idle(3, 5'd5);

    for (int i = 1; i <= 5; i++) push(AS'(i), 32'hA000 + i, AS'(i));
    idle(3, 5'd3);

    push(5'd7, 32'h11, 5'd7);
    push(5'd7, 32'h22, 5'd7);
    idle(3, 5'd7);
    idle(1, 5'd0);

    push(5'd0, 32'hFFFFFFFF, 5'd0);
    chk("zero_idx_Pending", bus.Pending, '0);
    idle(3, 5'd0);

    push(5'd10, 32'hC1, 5'd10);
    push(5'd11, 32'hC2, 5'd11);
    push(5'd12, 32'hC3, 5'd12);
    async_reset();
    idle(36, 5'd12);

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, AS'($urandom_range(0, 7)), $urandom,
            AS'($urandom_range(0, 7)), acc);
      if (i == 150) async_reset();
    end
    idle(4, 5'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
